// File: rtl/instr_pf_pkg.sv
// Shared types and helpers for the instruction prefetch buffer.
// Word geometry is derived from the instruction word width.
package instr_pf_pkg;

  localparam int PF_AW     = 16;
  localparam int PF_DW     = 32;
  localparam int PF_WB     = PF_DW / 8;
  localparam int PF_WB_LOG = $clog2(PF_WB);

  typedef struct packed {
    logic [PF_AW-1:0] addr;
    logic [PF_DW-1:0] data;
  } pf_entry_t;

  function automatic logic [PF_AW-1:0] addr_align(
    input logic [PF_AW-1:0] a
  );
    return {a[PF_AW-1:PF_WB_LOG], {PF_WB_LOG{1'b0}}};
  endfunction

endpackage

// File: rtl/instr_pf_fifo.sv
// Small prefetch FIFO of {addr, data} entries.
// Push and pop may coincide, even when full; flush wins over both.
module instr_pf_fifo
  import instr_pf_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      flush_i,
  input  pf_entry_t data_i,
  output pf_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic      empty_o,
  output logic      full_o
);

  pf_entry_t     mem_q [DEPTH];
  logic [PW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= inc(wptr_q);
      end
      if (do_pop)
        rptr_q <= inc(rptr_q);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/instr_prefetch_buf.sv
// Sequential instruction prefetch buffer in front of the instruction RAM.
// Serves straight-line fetches from a FIFO, one cycle response latency.
module instr_prefetch_buf
  import instr_pf_pkg::*;
#(
  parameter int ADDR_WIDTH = PF_AW,
  parameter int DATA_WIDTH = PF_DW,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  input  logic                  pf_en_i,
  input  logic                  flush_i,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int MSB = ADDR_WIDTH - 1;
  localparam int WB  = DATA_WIDTH / 8;

  pf_entry_t       head, push_ent;
  logic [CW-1:0]   cnt;
  logic            empty, full;
  logic [MSB:0]    req_addr;
  logic            head_hit, infl_hit, hit, miss;
  logic            pop, push, issue, fifo_flush;
  logic [CW:0]     occ;
  logic [MSB+1:0]  nxt_inc;

  logic            infl_q, infl_d;
  logic [MSB:0]    infl_addr_q, infl_addr_d;
  logic [MSB:0]    nxt_addr_q, nxt_addr_d;
  logic            pf_act_q, pf_act_d;
  logic            dmsb_q, dmsb_d;
  logic            rv_q, rv_d;
  logic            rsrc_q, rsrc_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    req_addr = addr_align(instr_addr_i);
    head_hit = instr_req_i && !flush_i && !empty
               && head.addr == req_addr;
    infl_hit = instr_req_i && !flush_i && empty
               && infl_q && infl_addr_q == req_addr;
    hit        = head_hit || infl_hit;
    miss       = instr_req_i && !hit;
    pop        = head_hit;
    push       = infl_q && !infl_hit && !miss
                 && !flush_i && (!full || pop);
    fifo_flush = miss || flush_i;
    // in-flight read counts against capacity until it lands
    occ = (CW+1)'(cnt) - (CW+1)'(pop)
          + (CW+1)'(push) + (CW+1)'(infl_q);
    nxt_inc = {1'b0, nxt_addr_q} + (MSB+2)'(WB);
    issue = !miss && !flush_i && pf_act_q && pf_en_i
            && occ < (CW+1)'(DEPTH)
            && nxt_addr_q[MSB] == dmsb_q;

    infl_d      = issue;
    infl_addr_d = issue ? nxt_addr_q : infl_addr_q;
    nxt_addr_d  = nxt_addr_q;
    pf_act_d    = pf_act_q;
    dmsb_d      = dmsb_q;
    rv_d        = instr_req_i;
    rsrc_d      = miss;
    rdata_d     = rdata_q;

    if (miss) begin
      nxt_addr_d = req_addr + MSB'(0) + (MSB+1)'(WB);
      pf_act_d   = pf_en_i;
      dmsb_d     = req_addr[MSB];
    end else begin
      if (flush_i)
        pf_act_d = 1'b0;
      else if (pf_act_q && nxt_addr_q[MSB] != dmsb_q)
        pf_act_d = 1'b0;
      if (issue) begin
        nxt_addr_d = nxt_inc[MSB:0];
        if (nxt_inc[MSB+1])
          pf_act_d = 1'b0;
      end
    end

    if (head_hit)
      rdata_d = head.data;
    else if (infl_hit)
      rdata_d = ram_rdata_i;
  end

  assign push_ent       = '{addr: infl_addr_q, data: ram_rdata_i};
  assign instr_gnt_o    = instr_req_i;
  assign ram_en_o       = miss || issue;
  assign ram_addr_o     = miss ? req_addr : nxt_addr_q;
  assign instr_rvalid_o = rv_q;
  assign instr_rdata_o  = rsrc_q ? ram_rdata_i : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      nxt_addr_q  <= '0;
      pf_act_q    <= 1'b0;
      dmsb_q      <= 1'b0;
      rv_q        <= 1'b0;
      rsrc_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      nxt_addr_q  <= nxt_addr_d;
      pf_act_q    <= pf_act_d;
      dmsb_q      <= dmsb_d;
      rv_q        <= rv_d;
      rsrc_q      <= rsrc_d;
      rdata_q     <= rdata_d;
    end
  end

  instr_pf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(fifo_flush),
    .data_i (push_ent),
    .head_o (head),
    .count_o(cnt),
    .empty_o(empty),
    .full_o (full)
  );

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Randomized bench for instr_prefetch_buf against a queue-based model.
// RAM is a bench function of address plus a salt bumped on each flush.
module tb_instr_prefetch_buf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [15:0] instr_addr_i = '0;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        pf_en_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ram_en_o;
  logic [15:0] ram_addr_o;
  logic [31:0] ram_rdata_i = '0;

  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] salt = 16'h5a5a;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  bit          m_infl, m_act, m_dmsb, m_rv;
  logic [15:0] m_infl_addr, m_nxt;
  logic [31:0] m_infl_data, m_rdata;

  instr_prefetch_buf #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .pf_en_i       (pf_en_i),
    .flush_i       (flush_i),
    .ram_en_o      (ram_en_o),
    .ram_addr_o    (ram_addr_o),
    .ram_rdata_i   (ram_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ salt, ~a};
  endfunction

  always @(posedge clk)
    if (ram_en_o)
      ram_rdata_i <= memf(ram_addr_o);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h (t=%0t)",
               tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_infl = 0;
    m_act  = 0;
    m_dmsb = 0;
    m_rv   = 0;
    m_nxt  = '0;
    m_infl_addr = '0;
  endtask

  task automatic step(input bit req, input logic [15:0] addr,
                      input bit pf, input bit fl);
    logic [15:0] a;
    logic [16:0] sum;
    bit hh, ih, miss, push, iss;
    int occ;
    @(negedge clk);
    if (fl) salt = salt + 16'h1357;
    instr_req_i  = req;
    instr_addr_i = addr;
    pf_en_i      = pf;
    flush_i      = fl;
    #1;
    a  = {addr[15:2], 2'b00};
    hh = req && !fl && q.size() > 0 && q[0].a == a;
    ih = req && !fl && q.size() == 0 && m_infl
         && m_infl_addr == a;
    miss = req && !(hh || ih);
    push = m_infl && !ih && !miss && !fl;
    occ  = q.size() - int'(hh) + int'(push) + int'(m_infl);
    iss  = !miss && !fl && m_act && pf && occ < DEPTH
           && m_nxt[15] == m_dmsb;

    chk("gnt", 32'(instr_gnt_o), 32'(req));
    chk("ram_en", 32'(ram_en_o), 32'(miss || iss));
    if (miss || iss)
      chk("ram_addr", 32'(ram_addr_o), 32'(miss ? a : m_nxt));
    chk("rvalid", 32'(instr_rvalid_o), 32'(m_rv));
    if (m_rv)
      chk("rdata", instr_rdata_o, m_rdata);

    m_rv = req;
    if (miss)    m_rdata = memf(a);
    else if (hh) m_rdata = q[0].d;
    else if (ih) m_rdata = m_infl_data;

    if (miss || fl) q.delete();
    else begin
      if (hh) void'(q.pop_front());
      if (push) q.push_back('{a: m_infl_addr, d: m_infl_data});
    end

    if (miss) begin
      m_nxt  = a + 16'd4;
      m_act  = pf;
      m_dmsb = a[15];
    end else begin
      if (fl) m_act = 0;
      else if (m_act && m_nxt[15] != m_dmsb) m_act = 0;
      if (iss) begin
        m_infl_addr = m_nxt;
        m_infl_data = memf(m_nxt);
        sum   = {1'b0, m_nxt} + 17'd4;
        m_nxt = sum[15:0];
        if (sum[16]) m_act = 0;
      end
    end
    m_infl = iss;
  endtask

  task automatic idle(input int n, input bit pf);
    for (int i = 0; i < n; i++) step(0, '0, pf, 0);
  endtask

  initial begin
    logic [15:0] la, ra;
    bit rq, pf, fl;
    int sel;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rvalid", 32'(instr_rvalid_o), 32'(0));
    chk("rst_ram_en", 32'(ram_en_o), 32'(0));
    rst_n = 1'b1;

    idle(3, 1);
    step(1, 16'h0000, 1, 0);
    idle(5, 1);
    step(1, 16'h0004, 1, 0);
    step(1, 16'h0008, 1, 0);
    step(1, 16'h000C, 1, 0);
    for (int i = 4; i < 12; i++)
      step(1, 16'(i * 4), 1, 0);
    step(0, '0, 1, 0);
    step(1, 16'h0000, 1, 0);
    idle(3, 1);
    step(1, 16'h0100, 1, 0);
    step(1, 16'h0104, 1, 0);
    idle(3, 1);
    step(1, 16'h7FF8, 1, 0);
    idle(6, 1);
    step(1, 16'h7FFC, 1, 0);
    idle(2, 1);
    step(1, 16'h0000, 1, 0);
    idle(4, 1);
    step(1, 16'h0004, 1, 1);
    step(1, 16'h0008, 1, 0);
    idle(3, 1);
    step(1, 16'h0200, 0, 0);
    idle(3, 0);
    step(1, 16'h0204, 0, 0);
    step(1, 16'h0208, 0, 0);
    step(1, 16'hFFFC, 1, 0);
    idle(3, 1);

    step(1, 16'h0040, 1, 0);
    @(negedge clk);
    instr_req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(instr_rvalid_o), 32'(0));
    chk("midrst_ram_en", 32'(ram_en_o), 32'(0));
    model_reset();
    #1 rst_n = 1'b1;
    idle(4, 1);

    la = 16'h1000;
    for (int i = 0; i < 1500; i++) begin
      rq  = $urandom_range(0, 99) < 80;
      sel = $urandom_range(0, 99);
      if (sel < 70)      ra = la + 16'd4;
      else if (sel < 85) ra = 16'($urandom_range(0, 65535));
      else if (sel < 92) ra = 16'h7FF0 + 16'($urandom_range(0, 15));
      else               ra = 16'hFFF0 + 16'($urandom_range(0, 15));
      pf = $urandom_range(0, 99) < 90;
      fl = $urandom_range(0, 99) < 4;
      step(rq, ra, pf, fl);
      if (rq) la = {ra[15:2], 2'b00};
    end
    idle(2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
